muldiv_engine: RTL and testbench

//  Multi-cycle multiply/divide responder behind the execute stage's start/busy handshake.

---
 rtl/muldiv_defs.sv | 39 +++
 rtl/muldiv_engine.sv | 146 ++++++++++++++
 tb/tb_muldiv_engine.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/muldiv_defs.sv
// Shared mul/div constants: MDOp encodings, FSM states, default latencies.
// MULDIV_MADD_EN adds madd/maddu (MDOp 9/10) to the launch set.
package muldiv_defs;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MFHI  = 4'd5;
  localparam logic [3:0] MD_MFLO  = 4'd6;
  localparam logic [3:0] MD_MTHI  = 4'd7;
  localparam logic [3:0] MD_MTLO  = 4'd8;
  localparam logic [3:0] MD_MADD  = 4'd9;
  localparam logic [3:0] MD_MADDU = 4'd10;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_t;

  function automatic logic is_mul_op(input logic [3:0] op);
`ifdef MULDIV_MADD_EN
    return (op == MD_MULT) || (op == MD_MULTU) ||
           (op == MD_MADD) || (op == MD_MADDU);
`else
    return (op == MD_MULT) || (op == MD_MULTU);
`endif
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_engine.sv
// Multi-cycle HI/LO multiply/divide unit behind the execute start/busy handshake.
// MULDIV_MADD_EN enables madd/maddu accumulate into {HI,LO}.
module muldiv_engine
  import muldiv_defs::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        req,
  input  logic [3:0]  MDOp,
  input  logic [31:0] D1,
  input  logic [31:0] D2,
  output logic        busy,
  output logic [31:0] result,
  output logic [31:0] HI_o,
  output logic [31:0] LO_o
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    op_q;
  logic [31:0]   a_q;
  logic [31:0]   b_q;
  logic [31:0]   hi;
  logic [31:0]   lo;

  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic signed [31:0] quo_s;
  logic signed [31:0] rem_s;
  logic [31:0]        quo_u;
  logic [31:0]        rem_u;
  logic               div_zero;
  logic               div_ovf;

  assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
  assign prod_u = {32'b0, a_q} * {32'b0, b_q};

  // Most-negative / -1 overflows the quotient; pin the architectural answer.
  assign div_zero = (b_q == 32'd0);
  assign div_ovf  = (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);

  always_comb begin
    quo_s = 32'sd0;
    rem_s = 32'sd0;
    quo_u = 32'd0;
    rem_u = 32'd0;
    if (div_ovf) begin
      quo_s = 32'sh8000_0000;
    end else if (!div_zero) begin
      quo_s = $signed(a_q) / $signed(b_q);
      rem_s = $signed(a_q) % $signed(b_q);
    end
    if (!div_zero) begin
      quo_u = a_q / b_q;
      rem_u = a_q % b_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      op_q  <= MD_NONE;
      a_q   <= '0;
      b_q   <= '0;
      hi    <= '0;
      lo    <= '0;
      busy  <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start && !req && is_mul_op(MDOp)) begin
            state <= ST_MUL;
            cnt   <= CW'(MULT_CYCLES);
            op_q  <= MDOp;
            a_q   <= D1;
            b_q   <= D2;
            busy  <= 1'b1;
          end else if (start && !req && is_div_op(MDOp)) begin
            state <= ST_DIV;
            cnt   <= CW'(DIV_CYCLES);
            op_q  <= MDOp;
            a_q   <= D1;
            b_q   <= D2;
            busy  <= 1'b1;
          end else if (!req && MDOp == MD_MTHI) begin
            hi <= D1;
          end else if (!req && MDOp == MD_MTLO) begin
            lo <= D1;
          end
        end
        ST_MUL, ST_DIV: begin
          if (cnt == CW'(1)) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
            unique case (1'b1)
              (op_q == MD_MULT):  {hi, lo} <= prod_s;
              (op_q == MD_MULTU): {hi, lo} <= prod_u;
              (op_q == MD_DIV): begin
                if (!div_zero) begin
                  lo <= quo_s;
                  hi <= rem_s;
                end
              end
              (op_q == MD_DIVU): begin
                if (!div_zero) begin
                  lo <= quo_u;
                  hi <= rem_u;
                end
              end
`ifdef MULDIV_MADD_EN
              (op_q == MD_MADD):  {hi, lo} <= {hi, lo} + prod_s;
              (op_q == MD_MADDU): {hi, lo} <= {hi, lo} + prod_u;
`endif
              default: ;
            endcase
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    result = 32'd0;
    if (MDOp == MD_MFHI) result = hi;
    else if (MDOp == MD_MFLO) result = lo;
  end

  assign HI_o = hi;
  assign LO_o = lo;

endmodule

// File: tb/tb_muldiv_engine.sv
// Directed self-checking bench for muldiv_engine.
// Build with MULDIV_MADD_EN to check madd/maddu accumulate.
module tb_muldiv_engine;
  import muldiv_defs::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        req;
  logic [3:0]  MDOp;
  logic [31:0] D1;
  logic [31:0] D2;
  logic        busy;
  logic [31:0] result;
  logic [31:0] HI_o;
  logic [31:0] LO_o;

  int errs = 0;
  int checks = 0;

  muldiv_engine dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .req    (req),
    .MDOp   (MDOp),
    .D1     (D1),
    .D2     (D2),
    .busy   (busy),
    .result (result),
    .HI_o   (HI_o),
    .LO_o   (LO_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic mt(input logic [3:0] op, input logic [31:0] d,
                    input logic rq);
    MDOp = op;
    D1   = d;
    req  = rq;
    @(posedge clk);
    #1;
    MDOp = MD_NONE;
    req  = 1'b0;
    chk("mt_busy", 32'(busy), 32'd0);
  endtask

  task automatic rd(input string tag, input logic [3:0] op,
                    input logic [31:0] exp);
    MDOp = op;
    #1;
    chk(tag, result, exp);
    MDOp = MD_NONE;
  endtask

  // Launch and count cycles with busy high after the launch edge.
  task automatic launch(input string tag, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic rq, input int ncyc,
                        input logic [31:0] ehi, input logic [31:0] elo);
    int n;
    start = 1'b1;
    MDOp  = op;
    D1    = a;
    D2    = b;
    req   = rq;
    @(posedge clk);
    #1;
    start = 1'b0;
    MDOp  = MD_NONE;
    req   = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(posedge clk);
      #1;
    end
    chk({tag, "_cyc"}, 32'(n), 32'(ncyc));
    chk({tag, "_hi"}, HI_o, ehi);
    chk({tag, "_lo"}, LO_o, elo);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    req   = 1'b0;
    MDOp  = MD_NONE;
    D1    = '0;
    D2    = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_hi", HI_o, 32'd0);
    chk("rst_lo", LO_o, 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    mt(MD_MTLO, 32'h1234_5678, 1'b0);
    mt(MD_MTHI, 32'hCAFE_BABE, 1'b0);
    rd("mflo", MD_MFLO, 32'h1234_5678);
    rd("mfhi", MD_MFHI, 32'hCAFE_BABE);
    rd("res_none", MD_NONE, 32'd0);

    launch("mult", MD_MULT, 32'hFFFF_FFFF, 32'd2, 1'b0, 5,
           32'hFFFF_FFFF, 32'hFFFF_FFFE);
    launch("multu", MD_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0, 5,
           32'h0000_0001, 32'hFFFF_FFFE);
    launch("div", MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 10,
           32'hFFFF_FFFF, 32'hFFFF_FFFD);
    rd("mflo_div", MD_MFLO, 32'hFFFF_FFFD);
    launch("divu0", MD_DIVU, 32'd7, 32'd0, 1'b0, 10,
           32'hFFFF_FFFF, 32'hFFFF_FFFD);
    launch("divu", MD_DIVU, 32'd100, 32'd7, 1'b0, 10,
           32'd2, 32'd14);
    launch("divovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 10,
           32'd0, 32'h8000_0000);

    launch("req", MD_MULT, 32'd3, 32'd3, 1'b1, 0,
           32'd0, 32'h8000_0000);
    mt(MD_MTHI, 32'h0000_0055, 1'b1);
    chk("mthi_req", HI_o, 32'd0);
    launch("badop", MD_MFHI, 32'd3, 32'd3, 1'b0, 0,
           32'd0, 32'h8000_0000);

    mt(MD_MTHI, 32'd0, 1'b0);
    mt(MD_MTLO, 32'hFFFF_FFFF, 1'b0);
`ifdef MULDIV_MADD_EN
    launch("maddu", MD_MADDU, 32'd1, 32'd1, 1'b0, 5,
           32'd1, 32'd0);
`else
    launch("maddu", MD_MADDU, 32'd1, 32'd1, 1'b0, 0,
           32'd0, 32'hFFFF_FFFF);
`endif

    mt(MD_MTHI, 32'hAAAA_0001, 1'b0);
    mt(MD_MTLO, 32'hBBBB_0002, 1'b0);
    start = 1'b1;
    MDOp  = MD_DIV;
    D1    = 32'd100;
    D2    = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("div_busy", 32'(busy), 32'd1);
    MDOp = MD_MFLO;
    #1;
    chk("mflo_busy", result, 32'hBBBB_0002);
    MDOp = MD_NONE;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_hi", HI_o, 32'd0);
    chk("abort_lo", LO_o, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("post_busy", 32'(busy), 32'd0);
    chk("post_hi", HI_o, 32'd0);
    chk("post_lo", LO_o, 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
